ps_kernel_ctrl: RTL and testbench
=================================

PS_KERNEL_CTRL -- requirements
Module: ps_kernel_ctrl

Interface
REQ-001 SHALL have parameter: LINE_WIDTH, 640, pixels per line (legal range 4..4096).
REQ-002 SHALL have port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: i_data  input  8  greyscale input pixel, raster order.
REQ-005 SHALL have port: i_valid  input  1  i_data qualifier; no backpressure to source.
REQ-006 SHALL have port: i_flush  input  1  synchronous frame restart; clears pointers and counters.
REQ-007 SHALL have port: o_r0_data  output  24  3-pixel window from oldest line.
REQ-008 SHALL have port: o_r1_data  output  24  3-pixel window from middle line.
REQ-009 SHALL have port: o_r2_data  output  24  3-pixel window from newest line.
REQ-010 SHALL have port: o_valid  output  1  qualifies o_r0/r1/r2_data for one cycle; drives the 3x3 kernel valid.
REQ-011 SHALL have port: o_overflow  output  1  sticky flag: pixel dropped, all buffers full.

Function
REQ-012 SHALL hold 4 line buffers, LINE_WIDTH x 8 bits each, used as a ring.
REQ-013 SHALL keep wr_sel (0..3), wr_col (0..LINE_WIDTH-1), rd_sel (0..3), rd_col (0..LINE_WIDTH-3), fill count cnt (0..4).
REQ-014 SHALL, on i_valid with cnt<4, write i_data to buffer wr_sel at wr_col, then increment wr_col.
REQ-015 SHALL, on a write at wr_col==LINE_WIDTH-1, wrap wr_col to 0, advance wr_sel mod 4, and increment cnt.
REQ-016 SHALL, on i_valid with cnt==4, drop the pixel, leave wr_sel/wr_col unchanged, and set o_overflow.
REQ-017 SHALL implement FSM IDLE/READ; IDLE->READ when cnt>=3.
REQ-018 SHALL, in READ, issue one window read per cycle at rd_col and increment rd_col.
REQ-019 SHALL form each window from buffers rd_sel, rd_sel+1, rd_sel+2 (mod 4) as r0, r1, r2.
REQ-020 SHALL pack each row as [23:16]=col rd_col, [15:8]=rd_col+1, [7:0]=rd_col+2.
REQ-021 SHALL, on the read at rd_col==LINE_WIDTH-3, wrap rd_col to 0, advance rd_sel mod 4, and decrement cnt.
REQ-022 SHALL, after that wrap, stay READ if updated cnt>=3, else go IDLE; no bubble cycle between lines when staying.
REQ-023 SHALL produce exactly LINE_WIDTH-2 windows per consumed line.
REQ-024 SHALL, on line completion by the writer and a line release by the reader in the same cycle, leave cnt unchanged.
REQ-025 SHALL register outputs: o_valid and window data appear 1 cycle after read issue; o_valid low on all other cycles.
REQ-026 SHALL hold o_r*_data at its last value while o_valid is low.
REQ-027 SHALL allow a write and a read to the same buffer in one cycle only at different columns; the ring guarantees the writer never targets rd_sel..rd_sel+2 while cnt<4.
REQ-028 SHALL, on i_flush, do the following: zero wr_sel/wr_col/rd_sel/rd_col/cnt, go IDLE, and clear o_valid next cycle; it has priority over a same-cycle i_valid. o_overflow is unaffected.

Reset
REQ-029 SHALL, while i_rstn low, force o_valid=0, o_r0/r1/r2_data=0, o_overflow=0, all pointers/cnt=0, FSM=IDLE, asynchronously.
REQ-030 SHALL NOT reset line buffer contents; stale data is never emitted because cnt=0.
REQ-031 SHALL, on reset mid-line or mid-READ, discard partial state; the first window after reset uses only post-reset pixels.

Verification
REQ-032 SHALL verify line fill: LINE_WIDTH=8, stream 24 pixels values 0..23 continuously -> first o_valid 2 cycles after pixel 23 is accepted; r0=0x000102, r1=0x08090A, r2=0x101112; 6 windows, the last being r0=0x050607.
REQ-033 SHALL verify steady state: LINE_WIDTH=8, 40 continuous pixels -> 18 windows on 3 lines; second line's first window has r0=0x08090A; o_overflow stays 0.
REQ-034 SHALL verify overflow: LINE_WIDTH=8, 33 pixels written while the reader is held IDLE by forcing cnt via early pixels -> 33rd pixel dropped, o_overflow=1 until i_rstn.
REQ-035 SHALL verify flush: i_flush asserted after 20 pixels -> no o_valid; next 24 pixels 100..123 give first window r0=0x646566.
REQ-036 SHALL verify async reset: i_rstn low mid-READ -> o_valid=0 and data=0 immediately, without waiting for a clock edge; no windows until 3 new lines are written.
REQ-037 SHALL verify gapped input: i_valid toggling 1/0 for 3 lines -> identical window values to the continuous case, and each o_valid pulse exactly 1 cycle wide.

Source files
------------

// File: rtl/ps_kernel_ctrl.sv
// ps_kernel_ctrl
//   Line-buffer controller feeding a 3x3 kernel. Incoming raster pixels are
//   stored in a ring of four line buffers. Once three complete lines are
//   held, the reader sweeps them column by column and emits one 3-pixel
//   window per row per cycle. A line is released back to the writer after
//   its last window.
//
// Ports
//   i_clk       sole clock, rising edge
//   i_rstn      asynchronous active-low reset
//   i_data      8-bit greyscale pixel, raster order
//   i_valid     i_data qualifier; the source cannot be stalled
//   i_flush     synchronous frame restart (clears pointers and counters)
//   o_r0_data   window from the oldest line   {col, col+1, col+2}
//   o_r1_data   window from the middle line
//   o_r2_data   window from the newest line
//   o_valid     one-cycle qualifier for the three window rows
//   o_overflow  sticky: a pixel arrived while all four buffers were full
module ps_kernel_ctrl #(
  parameter int LINE_WIDTH = 640
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_flush,
  output logic [23:0] o_r0_data,
  output logic [23:0] o_r1_data,
  output logic [23:0] o_r2_data,
  output logic        o_valid,
  output logic        o_overflow
);

  localparam int DATA_W = 8;
  localparam int COL_W  = $clog2(LINE_WIDTH);
  localparam logic [COL_W-1:0] WR_LAST = COL_W'(LINE_WIDTH - 1);
  localparam logic [COL_W-1:0] RD_LAST = COL_W'(LINE_WIDTH - 3);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] line_mem [4][LINE_WIDTH];

  logic [1:0]        wr_sel;
  logic [COL_W-1:0]  wr_col;
  logic [1:0]        rd_sel;
  logic [COL_W-1:0]  rd_col;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nxt;

  logic              wr_acc;
  logic              wr_wrap;
  logic              wr_drop;
  logic              vld_p0;
  logic              rd_wrap;

  logic [1:0]        sel1;
  logic [1:0]        sel2;
  logic [COL_W-1:0]  col1;
  logic [COL_W-1:0]  col2;

  // Write side: accept while at least one buffer is free; flush wins.
  assign wr_acc  = i_valid && !i_flush && (cnt != 3'd4);
  assign wr_wrap = wr_acc && (wr_col == WR_LAST);
  assign wr_drop = i_valid && !i_flush && (cnt == 3'd4);

  // Read side: one window issued every cycle spent in READ.
  assign vld_p0  = (state == S_READ);
  assign rd_wrap = vld_p0 && (rd_col == RD_LAST);

  // Ring neighbours wrap naturally in 2 bits; rd_col never exceeds
  // LINE_WIDTH-3 so the +2 column stays inside the line.
  assign sel1 = rd_sel + 2'd1;
  assign sel2 = rd_sel + 2'd2;
  assign col1 = rd_col + COL_W'(1);
  assign col2 = rd_col + COL_W'(2);

  // A completed line and a released line in the same cycle cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (wr_wrap && !rd_wrap) begin
      cnt_nxt = cnt + 3'd1;
    end else if (!wr_wrap && rd_wrap) begin
      cnt_nxt = cnt - 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cnt >= 3'd3) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        // Staying in READ after a wrap starts the next line immediately.
        if (rd_wrap && (cnt_nxt < 3'd3)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      state_nxt = S_IDLE;
    end
  end

  // Stage p0: pointers, fill count and FSM state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= S_IDLE;
      wr_sel <= '0;
      wr_col <= '0;
      rd_sel <= '0;
      rd_col <= '0;
      cnt    <= '0;
    end else if (i_flush) begin
      state  <= S_IDLE;
      wr_sel <= '0;
      wr_col <= '0;
      rd_sel <= '0;
      rd_col <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (wr_acc) begin
        wr_col <= wr_wrap ? '0 : wr_col + COL_W'(1);
      end
      if (wr_wrap) begin
        wr_sel <= wr_sel + 2'd1;
      end
      if (vld_p0) begin
        rd_col <= rd_wrap ? '0 : rd_col + COL_W'(1);
      end
      if (rd_wrap) begin
        rd_sel <= rd_sel + 2'd1;
      end
    end
  end

  // Sticky overflow: only reset clears it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_overflow <= 1'b0;
    end else if (wr_drop) begin
      o_overflow <= 1'b1;
    end
  end

  // Line storage has no reset; cnt gates every read of it.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      line_mem[wr_sel][wr_col] <= i_data;
    end
  end

  // Stage p1: registered window rows, held while no window is issued.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid   <= 1'b0;
      o_r0_data <= '0;
      o_r1_data <= '0;
      o_r2_data <= '0;
    end else begin
      o_valid <= vld_p0 && !i_flush;
      if (vld_p0 && !i_flush) begin
        o_r0_data <= {line_mem[rd_sel][rd_col], line_mem[rd_sel][col1], line_mem[rd_sel][col2]};
        o_r1_data <= {line_mem[sel1][rd_col],   line_mem[sel1][col1],   line_mem[sel1][col2]};
        o_r2_data <= {line_mem[sel2][rd_col],   line_mem[sel2][col1],   line_mem[sel2][col2]};
      end
    end
  end

endmodule

// File: tb/tb_ps_kernel_ctrl.sv
// Bench for ps_kernel_ctrl at LINE_WIDTH=8: a scenario table of pixel
// streams with expected window counts and boundary windows, plus directed
// sequences for latency, overflow, flush and asynchronous reset.
module tb_ps_kernel_ctrl;

  localparam int LW = 8;
  localparam int WPL = LW - 2;

  logic        clk;
  logic        rstn;
  logic [7:0]  data;
  logic        valid;
  logic        flush;
  logic [23:0] r0;
  logic [23:0] r1;
  logic [23:0] r2;
  logic        ovld;
  logic        ovf;

  ps_kernel_ctrl #(.LINE_WIDTH(LW)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_data     (data),
    .i_valid    (valid),
    .i_flush    (flush),
    .o_r0_data  (r0),
    .o_r1_data  (r1),
    .o_r2_data  (r2),
    .o_valid    (ovld),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] q2[$];

  always @(negedge clk) begin
    if (ovld) begin
      q0.push_back(r0);
      q1.push_back(r1);
      q2.push_back(r2);
    end
  end

  typedef struct {
    int          npix;
    logic [7:0]  base;
    bit          gap;
    int          nwin;
    logic [23:0] first_r0;
    logic [23:0] last_r0;
  } scen_t;

  scen_t scen [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row of three consecutive pixels from line 'ln', starting at column c.
  function automatic logic [23:0] row(input logic [7:0] base, input int ln, input int c);
    logic [7:0] p;
    p = base + 8'(ln * LW + c);
    return {p, p + 8'd1, p + 8'd2};
  endfunction

  task automatic clear_q();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    flush = 1'b0;
    data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_q();
  endtask

  task automatic send(input logic [7:0] v, input bit gap);
    valid = 1'b1;
    data  = v;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream(input logic [7:0] base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send(base + 8'(i), gap);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare captured windows against consecutive lines starting at line 0.
  task automatic check_windows(input string tag, input logic [7:0] base, input int nwin);
    check({tag, ".count"}, q0.size(), nwin);
    for (int k = 0; k < nwin && k < q0.size(); k++) begin
      check($sformatf("%s.w%0d.r0", tag, k), q0[k], row(base, k / WPL,     k % WPL));
      check($sformatf("%s.w%0d.r1", tag, k), q1[k], row(base, k / WPL + 1, k % WPL));
      check($sformatf("%s.w%0d.r2", tag, k), q2[k], row(base, k / WPL + 2, k % WPL));
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rstn   = 1'b0;
    valid  = 1'b0;
    flush  = 1'b0;
    data   = 8'd0;

    scen[0] = '{npix: 24, base: 8'd0,   gap: 1'b0, nwin: 6,  first_r0: 24'h000102, last_r0: 24'h050607};
    scen[1] = '{npix: 40, base: 8'd0,   gap: 1'b0, nwin: 18, first_r0: 24'h000102, last_r0: 24'h151617};
    scen[2] = '{npix: 24, base: 8'd0,   gap: 1'b1, nwin: 6,  first_r0: 24'h000102, last_r0: 24'h050607};
    scen[3] = '{npix: 24, base: 8'd100, gap: 1'b0, nwin: 6,  first_r0: 24'h646566, last_r0: 24'h696A6B};

    #2;
    check("rst.o_valid", ovld, 0);
    check("rst.r0", r0, 0);
    check("rst.r1", r1, 0);
    check("rst.r2", r2, 0);
    check("rst.overflow", ovf, 0);

    for (int s = 0; s < 4; s++) begin
      do_reset();
      stream(scen[s].base, scen[s].npix, scen[s].gap);
      idle(24);
      check_windows($sformatf("scen%0d", s), scen[s].base, scen[s].nwin);
      if (q0.size() > 0) begin
        check($sformatf("scen%0d.first_r0", s), q0[0], scen[s].first_r0);
        check($sformatf("scen%0d.last_r0", s), q0[q0.size()-1], scen[s].last_r0);
      end
      check($sformatf("scen%0d.hold_r0", s), r0, scen[s].last_r0);
      check($sformatf("scen%0d.overflow", s), ovf, 0);
      if (s == 1 && q0.size() > 6) begin
        check("scen1.line2_first_r0", q0[6], 24'h08090A);
      end
    end

    // First-window latency: o_valid two cycles after pixel 23 is taken.
    do_reset();
    stream(8'd0, 24, 1'b0);
    @(negedge clk);
    check("lat.cycle1", ovld, 0);
    @(negedge clk);
    check("lat.cycle2_pre", ovld, 0);
    @(negedge clk);
    check("lat.first_valid", ovld, 1);
    check("lat.r0", r0, 24'h000102);
    check("lat.r1", r1, 24'h08090A);
    check("lat.r2", r2, 24'h101112);

    // Overflow: hold the reader off so all four buffers fill.
    do_reset();
    force dut.vld_p0 = 1'b0;
    stream(8'd0, 32, 1'b0);
    @(negedge clk);
    check("ovf.full_no_flag", ovf, 0);
    #4;
    send(8'hEE, 1'b0);
    @(negedge clk);
    check("ovf.flag_set", ovf, 1);
    check("ovf.no_windows_held", q0.size(), 0);
    #4;
    release dut.vld_p0;
    idle(30);
    check("ovf.windows", q0.size(), 12);
    if (q0.size() >= 12) begin
      check("ovf.w0.r0", q0[0], 24'h000102);
      check("ovf.w0.r2", q2[0], 24'h101112);
      check("ovf.w6.r0", q0[6], 24'h08090A);
      check("ovf.w6.r2", q2[6], 24'h18191A);
    end
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);
    check("ovf.sticky_after_flush", ovf, 1);
    do_reset();
    check("ovf.cleared_by_reset", ovf, 0);

    // Flush after a partial fill: writer restarts at buffer 0 column 0.
    do_reset();
    stream(8'd0, 20, 1'b0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(6);
    check("flush.no_windows", q0.size(), 0);
    stream(8'd100, 24, 1'b0);
    idle(24);
    check("flush.count", q0.size(), 6);
    if (q0.size() > 0) begin
      check("flush.first_r0", q0[0], 24'h646566);
      check("flush.first_r2", q2[0], 24'h747576);
    end

    // Asynchronous reset in the middle of READ.
    do_reset();
    stream(8'd0, 24, 1'b0);
    repeat (3) @(negedge clk);
    check("arst.pre_valid", ovld, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst.o_valid", ovld, 0);
    check("arst.r0", r0, 0);
    check("arst.r1", r1, 0);
    check("arst.r2", r2, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_q();
    stream(8'd50, 16, 1'b0);
    idle(10);
    check("arst.two_lines_no_win", q0.size(), 0);
    stream(8'd66, 8, 1'b0);
    idle(24);
    check_windows("arst", 8'd50, 6);
    if (q0.size() > 0) begin
      check("arst.first_r0", q0[0], 24'h323334);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
